// File: rtl/ultrasonic_scan_ctrl.sv
// Multi-channel ultrasonic ranging sequencer: walks a channel mask, triggers each
// sensor through an external mux and times its echo in prescaled distance units.
`timescale 1ns/1ps
module ultrasonic_scan_ctrl #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SEL_W          = 4,
    parameter int unsigned DIST_W         = 16,
    parameter int unsigned PRESC          = 50,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned SETTLE_CYCLES  = 50,
    parameter int unsigned TIMEOUT_UNITS  = 30000,
    parameter int unsigned HOLDOFF_CYCLES = 3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [DIST_W-1:0] threshold,
    input  logic              echo_rx,
    output logic              trig_tx,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic [SEL_W-1:0]  rd_ch,
    output logic [DIST_W-1:0] rd_data,
    output logic              result_valid,
    output logic [SEL_W-1:0]  result_ch,
    output logic [DIST_W-1:0] result_data,
    output logic [NUM_CH-1:0] timeout_mask,
    output logic [NUM_CH-1:0] near_mask,
    output logic              busy,
    output logic              scan_done
);

    localparam int unsigned CYC_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF
    } state_e;

    state_e              state_q, state_d;
    logic                echo_s1_q, echo_s2_q, echo_p_q;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [DIST_W-1:0]   unit_q, unit_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]    cur_q, cur_d;
    logic [DIST_W-1:0]   res_q [NUM_CH];
    logic [DIST_W-1:0]   res_d [NUM_CH];
    logic                trig_tx_q, trig_tx_d;
    logic [SEL_W-1:0]    mux_sel_q, mux_sel_d;
    logic                result_valid_q, result_valid_d;
    logic [SEL_W-1:0]    result_ch_q, result_ch_d;
    logic [DIST_W-1:0]   result_data_q, result_data_d;
    logic [NUM_CH-1:0]   timeout_q, timeout_d;
    logic [NUM_CH-1:0]   near_q, near_d;
    logic                busy_q, busy_d;
    logic                scan_done_q, scan_done_d;

    logic                rise_c, fall_c, tmo_c, tick_c;
    logic                fin_ok_c, fin_to_c, last_c, relatch_c;
    logic [SEL_W:0]      first_c, next_c;

    // Lowest set bit of m at or above index 'from'; MSB flags whether one exists.
    function automatic logic [SEL_W:0] find_ch(input logic [NUM_CH-1:0] m, input int unsigned from);
        logic [SEL_W:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (m[i] && (i >= from) && !r[SEL_W]) r = {1'b1, SEL_W'(i)};
        end
        return r;
    endfunction

    assign first_c = find_ch(ch_mask, 32'd0);
    assign next_c  = find_ch(mask_q, 32'(cur_q) + 32'd1);
    assign rise_c  = echo_s2_q & ~echo_p_q;
    assign fall_c  = ~echo_s2_q & echo_p_q;
    assign tmo_c   = (unit_q >= DIST_W'(TIMEOUT_UNITS));
    assign tick_c  = (cyc_q == CYC_W'(PRESC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        fin_ok_c  = 1'b0;
        fin_to_c  = 1'b0;
        last_c    = 1'b0;
        relatch_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && (|ch_mask) && (mode || start)) begin
                    state_d   = S_SELECT;
                    relatch_c = 1'b1;
                end
            end
            S_SELECT:    if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) state_d = S_TRIG;
            S_TRIG:      if (cyc_q == CYC_W'(TRIG_CYCLES - 1))   state_d = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (rise_c) state_d = S_MEASURE;
                else if (tmo_c) begin
                    state_d  = S_HOLDOFF;
                    fin_to_c = 1'b1;
                end
            end
            S_MEASURE: begin
                if (fall_c) begin
                    state_d  = S_HOLDOFF;
                    fin_ok_c = 1'b1;
                end else if (tmo_c) begin
                    state_d  = S_HOLDOFF;
                    fin_to_c = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cyc_q == CYC_W'(HOLDOFF_CYCLES - 1)) begin
                    if (next_c[SEL_W]) begin
                        state_d = S_SELECT;
                    end else begin
                        last_c = 1'b1;
                        if (mode && (|ch_mask)) begin
                            state_d   = S_SELECT;
                            relatch_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort discards the in-flight channel without reporting it
        if (!enable) begin
            state_d   = S_IDLE;
            fin_ok_c  = 1'b0;
            fin_to_c  = 1'b0;
            last_c    = 1'b0;
            relatch_c = 1'b0;
        end
    end

    always_comb begin
        cyc_d = '0;
        if ((state_d == state_q) && (state_q != S_IDLE)) begin
            if (((state_q == S_WAIT_RISE) || (state_q == S_MEASURE)) && tick_c) cyc_d = '0;
            else cyc_d = cyc_q + CYC_W'(1);
        end

        // Unit counter clears on every state change, so TRIG exit and echo rise both restart it
        unit_d = '0;
        if ((state_d == state_q) && ((state_q == S_WAIT_RISE) || (state_q == S_MEASURE))) begin
            unit_d = unit_q;
            if (tick_c && (unit_q != '1)) unit_d = unit_q + DIST_W'(1);
        end

        mask_d = mask_q;
        cur_d  = cur_q;
        if (relatch_c) begin
            mask_d = ch_mask;
            cur_d  = first_c[SEL_W-1:0];
        end else if ((state_q == S_HOLDOFF) && (state_d == S_SELECT)) begin
            cur_d = next_c[SEL_W-1:0];
        end

        mux_sel_d      = cur_d;
        trig_tx_d      = (state_d == S_TRIG);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = fin_ok_c | fin_to_c;
        scan_done_d    = last_c;
        result_ch_d    = result_ch_q;
        result_data_d  = result_data_q;
        timeout_d      = timeout_q;
        near_d         = near_q;
        res_d          = res_q;
        if (fin_ok_c || fin_to_c) begin
            result_ch_d   = cur_q;
            result_data_d = fin_ok_c ? unit_q : '1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cur_q == SEL_W'(i)) begin
                    res_d[i]     = result_data_d;
                    timeout_d[i] = fin_to_c;
                    near_d[i]    = fin_ok_c && (unit_q < threshold);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1_q      <= 1'b0;
            echo_s2_q      <= 1'b0;
            echo_p_q       <= 1'b0;
            cyc_q          <= '0;
            unit_q         <= '0;
            mask_q         <= '0;
            cur_q          <= '0;
            res_q          <= '{default: '0};
            trig_tx_q      <= 1'b0;
            mux_sel_q      <= '0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_data_q  <= '0;
            timeout_q      <= '0;
            near_q         <= '0;
            busy_q         <= 1'b0;
            scan_done_q    <= 1'b0;
        end else begin
            echo_s1_q      <= echo_rx;
            echo_s2_q      <= echo_s1_q;
            echo_p_q       <= echo_s2_q;
            cyc_q          <= cyc_d;
            unit_q         <= unit_d;
            mask_q         <= mask_d;
            cur_q          <= cur_d;
            res_q          <= res_d;
            trig_tx_q      <= trig_tx_d;
            mux_sel_q      <= mux_sel_d;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_data_q  <= result_data_d;
            timeout_q      <= timeout_d;
            near_q         <= near_d;
            busy_q         <= busy_d;
            scan_done_q    <= scan_done_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_ch == SEL_W'(i)) rd_data = res_q[i];
        end
    end

    assign trig_tx      = trig_tx_q;
    assign mux_sel      = mux_sel_q;
    assign result_valid = result_valid_q;
    assign result_ch    = result_ch_q;
    assign result_data  = result_data_q;
    assign timeout_mask = timeout_q;
    assign near_mask    = near_q;
    assign busy         = busy_q;
    assign scan_done    = scan_done_q;

endmodule

// File: doc/ultrasonic_scan_ctrl.md
Name: ultrasonic_scan_ctrl

Overview:
- Parametrised multi-channel ultrasonic ranging sequencer; successor to the fixed 4-bit mux trig/echo path of the robot controller.
- Walks an enabled-channel mask, drives the external sensor mux select, fires one trigger per channel and times the echo with a prescaled counter.
- Stores per-channel distances, flags timeouts and raises per-channel proximity flags against a threshold.
- Supports single-shot and continuous scan modes; feeds obstacle logic and the UART telemetry path.

Parameters:
- NUM_CH, 4: number of sensor channels, 1..16.
- SEL_W, 4: mux select width; 2**SEL_W >= NUM_CH.
- DIST_W, 16: distance/result width.
- PRESC, 50: clk cycles per distance unit (1 us at 50 MHz).
- TRIG_CYCLES, 500: trigger high time in clk cycles.
- SETTLE_CYCLES, 50: mux settle time before trigger, in clk cycles.
- TIMEOUT_UNITS, 30000: maximum wait for echo rise plus echo width, in distance units.
- HOLDOFF_CYCLES, 3000: gap after each channel before the next select.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: block enable; low aborts and idles.
- mode, input, 1: 0 = single-shot on start, 1 = continuous.
- start, input, 1: single-cycle pulse; starts one scan when idle and mode=0.
- ch_mask, input, NUM_CH: channels included in a scan.
- threshold, input, DIST_W: proximity threshold.
- echo_rx, input, 1: asynchronous echo from mux output.
- trig_tx, output, 1: trigger to selected sensor.
- mux_sel, output, SEL_W: sensor mux select.
- rd_ch, input, SEL_W: result read index.
- rd_data, output, DIST_W: stored result of rd_ch, combinational; 0 if rd_ch >= NUM_CH.
- result_valid, output, 1: one-cycle pulse when a channel completes.
- result_ch, output, SEL_W: channel of the latest result.
- result_data, output, DIST_W: value of the latest result.
- timeout_mask, output, NUM_CH: per-channel flag; last measurement timed out.
- near_mask, output, NUM_CH: per-channel flag; last valid result < threshold.
- busy, output, 1: high in every state except IDLE.
- scan_done, output, 1: one-cycle pulse after the last masked channel.

Behaviour:
- Reset values: trig_tx=0, mux_sel=0, result regs=0, result_valid=0, result_ch=0, result_data=0, timeout_mask=0, near_mask=0, busy=0, scan_done=0. FSM enters IDLE.
- echo_rx passes through a 2-FF synchronizer. All edges below refer to the synchronized signal, which is 2 cycles late.
- FSM states: IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE -> SELECT when enable=1, ch_mask != 0, and (mode=1 or start=1). ch_mask is latched at this point and ignored for the rest of the scan.
- SELECT: mux_sel = lowest latched set bit at or above the current index. Hold SELECT for SETTLE_CYCLES, then go to TRIG.
- TRIG: trig_tx=1 for exactly TRIG_CYCLES, then go to WAIT_RISE. The prescaler and unit counter clear on TRIG exit.
- WAIT_RISE: the unit counter increments every PRESC cycles. A rising echo clears the counter and moves to MEASURE. Counter reaching TIMEOUT_UNITS is a timeout.
- MEASURE: counter increments every PRESC cycles. A falling echo makes the result = counter. Counter reaching TIMEOUT_UNITS is a timeout.
- Counter saturates at 2**DIST_W-1 and never wraps.
- Normal completion, in the cycle after the falling edge is detected:
  - Store the result and pulse result_valid with result_ch/result_data.
  - Clear timeout_mask[ch].
  - Set near_mask[ch] = (result < threshold), unsigned compare.
- Timeout: store result all-ones, pulse result_valid, set timeout_mask[ch]=1, clear near_mask[ch].
- HOLDOFF lasts HOLDOFF_CYCLES. Afterwards, advance to the next latched set bit:
  - If none remains, pulse scan_done in the same cycle as leaving HOLDOFF.
  - mode=1 and enable=1: go to SELECT at the lowest set bit of a newly latched ch_mask. If the new mask is 0, go to IDLE.
  - Otherwise go to IDLE.
- start is ignored when busy=1 or mode=1.
- enable low in any state: next cycle go to IDLE with trig_tx=0. Stored results and flags are kept. The in-flight channel produces no result_valid and no scan_done.
- Echo already high when entering WAIT_RISE: wait for a genuine rising edge.
- rst_n asserted mid-scan: all outputs return to reset values immediately, regardless of clk.

Test Plan (PRESC=2, TRIG_CYCLES=4, SETTLE_CYCLES=2, HOLDOFF_CYCLES=3, TIMEOUT_UNITS=100, NUM_CH=4):
- Single shot, ch_mask=4'b0101, echo held high 40 cycles on both channels:
  - mux_sel goes 0 then 2; trig_tx is high 4 cycles per channel.
  - result_valid fires twice with result_data=20 (±1); scan_done fires once; busy then drops.
- ch_mask=4'b1000, no echo -> result_data=16'hFFFF, timeout_mask=4'b1000, near_mask[3]=0, rd_ch=3 returns FFFF.
- threshold=25, echo widths of 20 and 60 units on ch1 and ch2 -> near_mask=4'b0010.
- mode=1, ch_mask=4'b0011 -> scans repeat back-to-back with scan_done every pass. Change ch_mask to 4'b0100 mid-pass -> the current pass completes unchanged and the next pass uses only ch2.
- Drop enable during MEASURE -> trig_tx=0 and IDLE in the next cycle, no result_valid, previous stored results unchanged. Also pulse start while busy -> ignored.
- Assert rst_n low during TRIG -> trig_tx=0 and busy=0 immediately. ch_mask=0 with start -> busy stays 0 and trig_tx never rises.
